// File: rtl/bus_arbiter.sv
// Two-master, one-slave bus arbiter: the CPU instruction and data ports share one memory bus.
// Round-robin on ties, registered slave-side fields, and a watchdog that force-completes stalls.
module bus_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_ibus_request,
    output logic        o_ibus_ready,
    input  logic [31:0] i_ibus_address,
    output logic [31:0] o_ibus_rdata,
    input  logic        i_dbus_rw,
    input  logic        i_dbus_request,
    output logic        o_dbus_ready,
    input  logic [31:0] i_dbus_address,
    input  logic [31:0] i_dbus_wdata,
    output logic [31:0] o_dbus_rdata,
    output logic        o_bus_rw,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    output logic        o_fault
);

    localparam int              CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit              WD_EN   = (TIMEOUT > 0);
    localparam logic [CW-1:0]   WD_LAST = WD_EN ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D
    } state_t;

    state_t          state;
    logic            last_grant_d;
    logic [CW-1:0]   wd_count;
    logic            timeout_hit;

    // The count equals (grant cycles so far - 1), so the forced completion lands
    // on the TIMEOUT-th cycle of the grant.
    always_comb begin
        timeout_hit = WD_EN && (state != IDLE) && !i_bus_ready && (wd_count == WD_LAST);
    end

    always_comb begin
        o_ibus_ready = (state == GRANT_I) && (i_bus_ready || timeout_hit);
        o_dbus_ready = (state == GRANT_D) && (i_bus_ready || timeout_hit);
        o_ibus_rdata = ((state == GRANT_I) && timeout_hit) ? 32'h0 : i_bus_rdata;
        o_dbus_rdata = ((state == GRANT_D) && timeout_hit) ? 32'h0 : i_bus_rdata;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            last_grant_d  <= 1'b1;
            wd_count      <= '0;
            o_bus_request <= 1'b0;
            o_bus_rw      <= 1'b0;
            o_bus_address <= 32'h0;
            o_bus_wdata   <= 32'h0;
            o_fault       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie the master that was not served last wins.
                    if (i_ibus_request && (!i_dbus_request || last_grant_d)) begin
                        state         <= GRANT_I;
                        o_bus_address <= i_ibus_address;
                        o_bus_rw      <= 1'b0;
                        o_bus_request <= 1'b1;
                        last_grant_d  <= 1'b0;
                        wd_count      <= '0;
                    end else if (i_dbus_request) begin
                        state         <= GRANT_D;
                        o_bus_address <= i_dbus_address;
                        o_bus_rw      <= i_dbus_rw;
                        o_bus_wdata   <= i_dbus_wdata;
                        o_bus_request <= 1'b1;
                        last_grant_d  <= 1'b1;
                        wd_count      <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (i_bus_ready || timeout_hit) begin
                        o_bus_request <= 1'b0;
                        state         <= IDLE;
                        if (timeout_hit) begin
                            o_fault <= 1'b1;
                        end
                    end else begin
                        wd_count <= wd_count + 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    o_bus_request <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a short watchdog (TIMEOUT=8).
module tb_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ibus_request;
    logic        ibus_ready;
    logic [31:0] ibus_address;
    logic [31:0] ibus_rdata;
    logic        dbus_rw;
    logic        dbus_request;
    logic        dbus_ready;
    logic [31:0] dbus_address;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        bus_rw;
    logic        bus_request;
    logic        bus_ready;
    logic [31:0] bus_address;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        fault;

    int total = 0;
    int bad   = 0;

    bus_arbiter #(.TIMEOUT(8)) dut (
        .i_clock        (clock),
        .i_reset_n      (reset_n),
        .i_ibus_request (ibus_request),
        .o_ibus_ready   (ibus_ready),
        .i_ibus_address (ibus_address),
        .o_ibus_rdata   (ibus_rdata),
        .i_dbus_rw      (dbus_rw),
        .i_dbus_request (dbus_request),
        .o_dbus_ready   (dbus_ready),
        .i_dbus_address (dbus_address),
        .i_dbus_wdata   (dbus_wdata),
        .o_dbus_rdata   (dbus_rdata),
        .o_bus_rw       (bus_rw),
        .o_bus_request  (bus_request),
        .i_bus_ready    (bus_ready),
        .o_bus_address  (bus_address),
        .o_bus_wdata    (bus_wdata),
        .i_bus_rdata    (bus_rdata),
        .o_fault        (fault)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just past the next rising edge; inputs change and checks happen here.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n      = 1'b1;
        ibus_request = 1'b0;
        ibus_address = 32'h0;
        dbus_rw      = 1'b0;
        dbus_request = 1'b0;
        dbus_address = 32'h0;
        dbus_wdata   = 32'h0;
        bus_ready    = 1'b0;
        bus_rdata    = 32'h0;
        #3;
        apply_reset();
        #1;
        check_output("rst_request", bus_request, 1'b0);
        check_output("rst_rw", bus_rw, 1'b0);
        check_output("rst_address", bus_address, 32'h0);
        check_output("rst_wdata", bus_wdata, 32'h0);
        check_output("rst_fault", fault, 1'b0);
        check_output("rst_ibus_ready", ibus_ready, 1'b0);
        check_output("rst_dbus_ready", dbus_ready, 1'b0);

        // Single fetch with slave ready one cycle after the bus request.
        ibus_request = 1'b1;
        ibus_address = 32'h0010_0000;
        step();
        #1;
        check_output("fetch_request", bus_request, 1'b1);
        check_output("fetch_address", bus_address, 32'h0010_0000);
        check_output("fetch_rw", bus_rw, 1'b0);
        check_output("fetch_wait_ready", ibus_ready, 1'b0);
        step();
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_0013;
        #1;
        check_output("fetch_ibus_ready", ibus_ready, 1'b1);
        check_output("fetch_ibus_rdata", ibus_rdata, 32'h0000_0013);
        check_output("fetch_dbus_ready", dbus_ready, 1'b0);
        step();
        ibus_request = 1'b0;
        bus_ready    = 1'b0;
        #1;
        check_output("fetch_release", bus_request, 1'b0);
        check_output("fetch_ibus_after", ibus_ready, 1'b0);

        // Tie straight after reset: ibus first, then the dbus write.
        apply_reset();
        ibus_request = 1'b1;
        ibus_address = 32'h0010_0004;
        dbus_request = 1'b1;
        dbus_rw      = 1'b1;
        dbus_address = 32'h2000_0000;
        dbus_wdata   = 32'hDEAD_BEEF;
        step();
        #1;
        check_output("tie_first_address", bus_address, 32'h0010_0004);
        check_output("tie_first_rw", bus_rw, 1'b0);
        check_output("tie_first_wdata", bus_wdata, 32'h0);
        bus_ready = 1'b1;
        #1;
        check_output("tie_first_ibus_ready", ibus_ready, 1'b1);
        check_output("tie_first_dbus_ready", dbus_ready, 1'b0);
        step();
        ibus_request = 1'b0;
        bus_ready    = 1'b0;
        #1;
        check_output("tie_gap_request", bus_request, 1'b0);
        step();
        #1;
        check_output("tie_second_request", bus_request, 1'b1);
        check_output("tie_second_address", bus_address, 32'h2000_0000);
        check_output("tie_second_rw", bus_rw, 1'b1);
        check_output("tie_second_wdata", bus_wdata, 32'hDEAD_BEEF);
        bus_ready = 1'b1;
        #1;
        check_output("tie_second_dbus_ready", dbus_ready, 1'b1);
        check_output("tie_second_ibus_ready", ibus_ready, 1'b0);
        step();
        dbus_request = 1'b0;
        bus_ready    = 1'b0;

        // Saturation: both hold requests; last grant was dbus, so ibus leads.
        begin
            int i_grants = 0;
            int d_grants = 0;
            ibus_request = 1'b1;
            ibus_address = 32'h0010_0100;
            dbus_request = 1'b1;
            dbus_rw      = 1'b1;
            dbus_address = 32'h2000_0100;
            dbus_wdata   = 32'h1234_5678;
            for (int k = 0; k < 10; k++) begin
                logic expect_i;
                expect_i = (k % 2 == 0);
                step();
                #1;
                check_output($sformatf("rr%0d_rw", k), bus_rw, expect_i ? 1'b0 : 1'b1);
                check_output($sformatf("rr%0d_address", k), bus_address,
                             expect_i ? 32'h0010_0100 : 32'h2000_0100);
                bus_ready = 1'b1;
                #1;
                check_output($sformatf("rr%0d_ibus_ready", k), ibus_ready, expect_i);
                check_output($sformatf("rr%0d_dbus_ready", k), dbus_ready, !expect_i);
                if (ibus_ready) i_grants++;
                if (dbus_ready) d_grants++;
                step();
                bus_ready = 1'b0;
            end
            check_output("rr_ibus_count", i_grants, 5);
            check_output("rr_dbus_count", d_grants, 5);
            ibus_request = 1'b0;
            dbus_request = 1'b0;
        end

        // Stray slave ready while idle.
        step();
        bus_ready = 1'b1;
        #1;
        check_output("stray_ibus_ready", ibus_ready, 1'b0);
        check_output("stray_dbus_ready", dbus_ready, 1'b0);
        step();
        bus_ready = 1'b0;
        #1;
        check_output("stray_request", bus_request, 1'b0);

        // Watchdog: dbus read, slave never answers; forced on the 8th grant cycle.
        dbus_request = 1'b1;
        dbus_rw      = 1'b0;
        dbus_address = 32'h3000_0000;
        step();
        #1;
        check_output("wd_request", bus_request, 1'b1);
        check_output("wd_rw", bus_rw, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            check_output($sformatf("wd_cycle%0d_ready", k), dbus_ready, 1'b0);
            step();
        end
        bus_rdata = 32'hCAFE_F00D;
        #1;
        check_output("wd_forced_ready", dbus_ready, 1'b1);
        check_output("wd_forced_rdata", dbus_rdata, 32'h0);
        check_output("wd_ibus_ready", ibus_ready, 1'b0);
        check_output("wd_ibus_rdata", ibus_rdata, 32'hCAFE_F00D);
        step();
        dbus_request = 1'b0;
        #1;
        check_output("wd_fault", fault, 1'b1);
        check_output("wd_release", bus_request, 1'b0);
        ibus_request = 1'b1;
        ibus_address = 32'h0010_0200;
        step();
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_0013;
        #1;
        check_output("wd_after_ibus_ready", ibus_ready, 1'b1);
        check_output("wd_after_ibus_rdata", ibus_rdata, 32'h0000_0013);
        step();
        ibus_request = 1'b0;
        bus_ready    = 1'b0;
        #1;
        check_output("wd_fault_sticky", fault, 1'b1);

        // Async reset in the middle of a dbus grant, between clock edges.
        dbus_request = 1'b1;
        dbus_rw      = 1'b1;
        dbus_address = 32'h2000_0300;
        dbus_wdata   = 32'h0BAD_F00D;
        step();
        bus_ready = 1'b1;
        #1;
        check_output("ar_pre_request", bus_request, 1'b1);
        check_output("ar_pre_dbus_ready", dbus_ready, 1'b1);
        reset_n = 1'b0;
        #1;
        check_output("ar_request", bus_request, 1'b0);
        check_output("ar_dbus_ready", dbus_ready, 1'b0);
        check_output("ar_ibus_ready", ibus_ready, 1'b0);
        check_output("ar_fault", fault, 1'b0);
        check_output("ar_address", bus_address, 32'h0);
        dbus_request = 1'b0;
        bus_ready    = 1'b0;
        step();
        reset_n = 1'b1;
        ibus_request = 1'b1;
        ibus_address = 32'h0010_0400;
        dbus_request = 1'b1;
        step();
        #1;
        check_output("ar_tie_rw", bus_rw, 1'b0);
        check_output("ar_tie_address", bus_address, 32'h0010_0400);
        bus_ready = 1'b1;
        #1;
        check_output("ar_tie_ibus_ready", ibus_ready, 1'b1);
        step();
        ibus_request = 1'b0;
        dbus_request = 1'b0;
        bus_ready    = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
